// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared instruction field map, format codes and encoder FSM states
package instr_encoder_pkg;

    // Field positions are numbered MSB-first: bit 0 is word bit 31.
    localparam int OPC_LO  = 0;
    localparam int OPC_HI  = 5;
    localparam int REGS_LO = 6;
    localparam int REGS_HI = 10;
    localparam int REGT_LO = 11;
    localparam int REGT_HI = 15;
    localparam int REGD_LO = 16;
    localparam int REGD_HI = 20;
    localparam int IMMI_LO = 16;
    localparam int IMMI_HI = 31;
    localparam int IMMJ_LO = 6;
    localparam int IMMJ_HI = 31;

    localparam int OPC_W  = OPC_HI  - OPC_LO  + 1;
    localparam int REGS_W = REGS_HI - REGS_LO + 1;
    localparam int REGT_W = REGT_HI - REGT_LO + 1;
    localparam int REGD_W = REGD_HI - REGD_LO + 1;
    localparam int IMMI_W = IMMI_HI - IMMI_LO + 1;
    localparam int IMMJ_W = IMMJ_HI - IMMJ_LO + 1;

    localparam int FMT_W = 2;

    typedef enum logic [FMT_W-1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when an unsigned operand fits in a field of w bits.
    function automatic logic fits(input logic [31:0] v, input int w);
        return (v >> w) == 32'd0;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - loader-side command/stream and memory write bundle for instr_encoder
interface instr_encoder_if
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              in_valid;
    logic              in_ready;
    logic [FMT_W-1:0]  fmt;
    logic [OPC_W-1:0]  opcode;
    logic [31:0]       dest;
    logic [31:0]       opA;
    logic [31:0]       opB;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    modport master (
        output start, base_addr, count, in_valid, fmt, opcode, dest, opA, opB,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_addr
    );

    modport slave (
        input  start, base_addr, count, in_valid, fmt, opcode, dest, opA, opB,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_addr
    );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packing of format/opcode/operands into a 32-bit instruction word
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [FMT_W-1:0] fmt_i,
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [31:0]      dest_i,
    input  logic [31:0]      opa_i,
    input  logic [31:0]      opb_i,
    output logic [31:0]      word_o,
    output logic             range_err_o
);

    // Place each field at its MSB-first slot; any range or format violation yields an all-zero word.
    always_comb begin
        word_o      = '0;
        range_err_o = 1'b0;
        word_o[31-OPC_LO -: OPC_W] = opcode_i;
        case (fmt_i)
            FMT_R: begin
                word_o[31-REGS_LO -: REGS_W] = dest_i[REGS_W-1:0];
                word_o[31-REGT_LO -: REGT_W] = opa_i[REGT_W-1:0];
                word_o[31-REGD_LO -: REGD_W] = opb_i[REGD_W-1:0];
                range_err_o = !fits(dest_i, REGS_W) || !fits(opa_i, REGT_W) || !fits(opb_i, REGD_W);
            end
            FMT_I: begin
                word_o[31-REGS_LO -: REGS_W] = dest_i[REGS_W-1:0];
                word_o[31-REGT_LO -: REGT_W] = opa_i[REGT_W-1:0];
                word_o[31-IMMI_LO -: IMMI_W] = opb_i[IMMI_W-1:0];
                range_err_o = !fits(dest_i, REGS_W) || !fits(opa_i, REGT_W) || !fits(opb_i, IMMI_W);
            end
            FMT_J: begin
                word_o[31-IMMJ_LO -: IMMJ_W] = opb_i[IMMJ_W-1:0];
                range_err_o = !fits(opb_i, IMMJ_W);
            end
            default: begin
                range_err_o = 1'b1;
            end
        endcase
        if (range_err_o) begin
            word_o = '0;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streams packed instruction words into instruction RAM with auto-increment
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    instr_encoder_if.slave bus
);

    state_e            state_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [31:0] word_d;
    logic        range_err_d;
    logic        accept;

    instr_pack u_pack (
        .fmt_i       (bus.fmt),
        .opcode_i    (bus.opcode),
        .dest_i      (bus.dest),
        .opa_i       (bus.opA),
        .opb_i       (bus.opB),
        .word_o      (word_d),
        .range_err_o (range_err_d)
    );

    assign bus.in_ready = (state_q == ST_LOAD) && (remaining_q != '0);
    assign accept       = bus.in_valid && bus.in_ready;

    // Load FSM, address/remaining counters and the registered memory write stage.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr_q      <= bus.base_addr;
                        remaining_q <= bus.count;
                        err_q       <= 1'b0;
                        state_q     <= (bus.count == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= word_d;
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - (ADDR_W+1)'(1);
                        if (range_err_d) begin
                            err_q <= 1'b1;
                            if (!err_q) begin
                                err_addr_q <= addr_q;
                            end
                        end
                        if (remaining_q == (ADDR_W+1)'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q == ST_LOAD);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
    assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic clock = 1'b0;
    logic reset = 1'b0;

    instr_encoder_if #(.ADDR_W(8)) bus ();

    instr_encoder #(.ADDR_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic go(input logic [7:0] base, input logic [8:0] cnt);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.count     = cnt;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic drive(input logic [1:0] f, input logic [5:0] op,
                         input logic [31:0] d, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.fmt      = f;
        bus.opcode   = op;
        bus.dest     = d;
        bus.opA      = a;
        bus.opB      = b;
    endtask

    logic [7:0] ea;

    initial begin
        bus.start = 0; bus.base_addr = 0; bus.count = 0; bus.in_valid = 0;
        bus.fmt = 0; bus.opcode = 0; bus.dest = 0; bus.opA = 0; bus.opB = 0;
        tick(); tick();

        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_busy_done", {30'd0, bus.busy, bus.done}, 0);
        check("rst_err", {23'd0, bus.err, bus.err_addr}, 0);
        reset = 1'b1;
        tick();

        // I-type single word
        go(8'h10, 9'd1);
        check("i_busy", 32'(bus.busy), 1);
        check("i_in_ready", 32'(bus.in_ready), 1);
        drive(2'd1, 6'h08, 3, 5, 32'h1234);
        tick();
        bus.in_valid = 1'b0;
        check("i_we", 32'(bus.mem_we), 1);
        check("i_addr", 32'(bus.mem_addr), 32'h10);
        check("i_wdata", bus.mem_wdata, 32'h20651234);
        check("i_done", 32'(bus.done), 1);
        check("i_busy_low", 32'(bus.busy), 0);
        check("i_err", 32'(bus.err), 0);
        tick();
        check("i_we_once", 32'(bus.mem_we), 0);
        check("i_done_once", 32'(bus.done), 0);

        // R then J back-to-back
        go(8'h20, 9'd2);
        drive(2'd0, 6'h00, 1, 2, 3);
        tick();
        check("r_we", 32'(bus.mem_we), 1);
        check("r_addr", 32'(bus.mem_addr), 32'h20);
        check("r_wdata", bus.mem_wdata, 32'h00221800);
        check("r_done", 32'(bus.done), 0);
        drive(2'd2, 6'h02, 0, 0, 32'h100);
        tick();
        bus.in_valid = 1'b0;
        check("j_we", 32'(bus.mem_we), 1);
        check("j_addr", 32'(bus.mem_addr), 32'h21);
        check("j_wdata", bus.mem_wdata, 32'h08000100);
        check("j_done", 32'(bus.done), 1);
        tick();

        // Range errors with sticky err_addr
        go(8'h05, 9'd3);
        drive(2'd1, 6'h08, 3, 5, 32'h10000);
        tick();
        check("e1_addr", 32'(bus.mem_addr), 32'h05);
        check("e1_wdata", bus.mem_wdata, 0);
        check("e1_err", 32'(bus.err), 1);
        check("e1_err_addr", 32'(bus.err_addr), 32'h05);
        drive(2'd0, 6'h00, 40, 2, 3);
        tick();
        check("e2_addr", 32'(bus.mem_addr), 32'h06);
        check("e2_wdata", bus.mem_wdata, 0);
        check("e2_err_addr", 32'(bus.err_addr), 32'h05);
        drive(2'd3, 6'h02, 0, 0, 32'h100);
        tick();
        bus.in_valid = 1'b0;
        check("e3_fmt_bad_wdata", bus.mem_wdata, 0);
        check("e3_addr", 32'(bus.mem_addr), 32'h07);
        check("e3_done", 32'(bus.done), 1);
        check("e3_err", {23'd0, bus.err, bus.err_addr}, {23'd0, 1'b1, 8'h05});
        tick();

        // Wrap with backpressure
        go(8'hFF, 9'd3);
        check("w_err_cleared", 32'(bus.err), 0);
        ea = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            drive(2'd2, 6'h01, 0, 0, 32'(i));
            bus.in_valid = (i % 2 == 0);
            tick();
            check($sformatf("w_we_%0d", i), 32'(bus.mem_we), 32'(i % 2 == 0));
            check($sformatf("w_done_%0d", i), 32'(bus.done), 32'(i == 4));
            if (i % 2 == 0) begin
                check($sformatf("w_addr_%0d", i), 32'(bus.mem_addr), 32'(ea));
                check($sformatf("w_wdata_%0d", i), bus.mem_wdata, 32'h04000000 | 32'(i));
                ea = ea + 8'd1;
            end
        end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("idle_valid_ignored", 32'(bus.mem_we), 0);

        // count = 0
        go(8'h30, 9'd0);
        check("c0_done", 32'(bus.done), 1);
        check("c0_we", 32'(bus.mem_we), 0);
        check("c0_busy", 32'(bus.busy), 0);
        tick();
        check("c0_done_once", 32'(bus.done), 0);

        // start during LOAD ignored
        go(8'h40, 9'd1);
        go(8'h80, 9'd5);
        drive(2'd2, 6'h02, 0, 0, 32'h100);
        tick();
        bus.in_valid = 1'b0;
        check("sl_addr", 32'(bus.mem_addr), 32'h40);
        check("sl_done", 32'(bus.done), 1);
        tick();

        // Reset mid-load
        go(8'h50, 9'd4);
        drive(2'd1, 6'h08, 3, 5, 32'h10000);
        tick();
        check("rm_err", 32'(bus.err), 1);
        drive(2'd0, 6'h00, 1, 2, 3);
        tick();
        check("rm_addr2", 32'(bus.mem_addr), 32'h51);
        drive(2'd2, 6'h02, 0, 0, 32'h100);
        reset = 1'b0;
        tick();
        check("rm_we", 32'(bus.mem_we), 0);
        check("rm_mem_addr", 32'(bus.mem_addr), 0);
        check("rm_wdata", bus.mem_wdata, 0);
        check("rm_flags", {28'd0, bus.in_ready, bus.busy, bus.done, bus.err}, 0);
        check("rm_err_addr", 32'(bus.err_addr), 0);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        go(8'h60, 9'd1);
        drive(2'd0, 6'h00, 1, 2, 3);
        tick();
        bus.in_valid = 1'b0;
        check("rs_addr", 32'(bus.mem_addr), 32'h60);
        check("rs_wdata", bus.mem_wdata, 32'h00221800);
        check("rs_err", 32'(bus.err), 0);
        check("rs_done", 32'(bus.done), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
